// File: rtl/univ_shift_burst.sv
// Parametrised universal shift register: hold/shift/load/rotate/arithmetic-shift with
// multi-position bursts under a valid/ready handshake. Optional USHIFT_PARITY_EN adds a parity output.
module univ_shift_burst #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CW-1:0]    shamt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             s_in_l,
  input  logic             s_in_r,
  output logic [WIDTH-1:0] q,
  output logic             s_out_l,
  output logic             s_out_r,
  output logic             busy,
  output logic             done
`ifdef USHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_LOAD = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5,
    MODE_ASHR = 3'd6,
    MODE_RSVD = 3'd7
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t           state, state_nxt;
  mode_t            op, op_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;

  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
           (m == MODE_ROTR) || (m == MODE_ASHR);
  endfunction

  // One-position move of v; serial inputs are taken live at each step.
  function automatic logic [WIDTH-1:0] step_op(input mode_t m, input logic [WIDTH-1:0] v,
                                               input logic sl, input logic sr);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SHL:  r = {v[WIDTH-2:0], sl};
      MODE_SHR:  r = {sr, v[WIDTH-1:1]};
      MODE_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROTR: r = {v[0], v[WIDTH-1:1]};
      MODE_ASHR: r = {v[WIDTH-1], v[WIDTH-1:1]};
      default:   r = v;
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] clamp_amt(input logic [CW-1:0] a);
    return (a > WIDTH_C) ? WIDTH_C : a;
  endfunction

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    count_nxt = count;
    q_nxt     = q;
    done_nxt  = 1'b0;
    if (ena) begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (mode_t'(mode) == MODE_LOAD) begin
              q_nxt    = d_in;
              done_nxt = 1'b1;
            end else if (is_shift(mode_t'(mode)) && (shamt != '0)) begin
              state_nxt = ST_RUN;
              op_nxt    = mode_t'(mode);
              count_nxt = clamp_amt(shamt);
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        ST_RUN: begin
          q_nxt     = step_op(op, q, s_in_l, s_in_r);
          count_nxt = count - CW'(1);
          if (count == CW'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op    <= MODE_HOLD;
      count <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      count <= count_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
    end
  end

`ifdef USHIFT_PARITY_EN
  // Registered alongside q so it always reflects the current contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= ^q_nxt;
  end
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign s_out_l   = q[WIDTH-1];
  assign s_out_r   = q[0];

endmodule

// File: tb/tb_univ_shift_burst.sv
// Bench for univ_shift_burst: directed test-plan steps followed by randomized commands,
// checked against a closed-form arithmetic model of each whole command.
module tb_univ_shift_burst;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    mode = 3'd0;
  logic [CW-1:0] shamt = '0;
  logic [W-1:0]  d_in = '0;
  logic          s_in_l = 1'b0;
  logic          s_in_r = 1'b0;
  logic [W-1:0]  q;
  logic          s_out_l;
  logic          s_out_r;
  logic          busy;
  logic          done;
`ifdef USHIFT_PARITY_EN
  logic          parity;
`endif

  int n_vec = 0;
  int n_err = 0;
  int last_lat = 0;
  logic [W-1:0] model_q = '0;

  univ_shift_burst #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mode(mode), .shamt(shamt), .d_in(d_in), .s_in_l(s_in_l), .s_in_r(s_in_r),
    .q(q), .s_out_l(s_out_l), .s_out_r(s_out_r), .busy(busy), .done(done)
`ifdef USHIFT_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-command result from plain arithmetic; serial inputs are held for the command.
  function automatic logic [W-1:0] model(input int m, input int n, input logic [W-1:0] qv,
                                         input logic [W-1:0] d, input logic sl, input logic sr);
    int mask = (1 << W) - 1;
    int v = int'(qv);
    int s;
    int r;
    case (m)
      1: r = (v << n) | (sl ? ((1 << n) - 1) : 0);
      2: r = int'(d);
      3: r = (v >> n) | (sr ? (mask << (W - n)) : 0);
      4: r = (v << n) | (v >> (W - n));
      5: r = (v >> n) | (v << (W - n));
      6: begin
        s = qv[W-1] ? v - (1 << W) : v;
        r = s >>> n;
      end
      default: r = v;
    endcase
    return W'(r & mask);
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_sol"}, s_out_l, q[W-1]);
    chk({tag, "_sor"}, s_out_r, q[0]);
`ifdef USHIFT_PARITY_EN
    chk({tag, "_par"}, parity, ^model_q);
`endif
  endtask

  // Entered and left at a negedge; leaves the bench in the cycle where done is visible.
  task automatic do_cmd(input int m, input int sh, input logic [W-1:0] d, input logic sl,
                        input logic sr, input int stall_at, input int stall_len,
                        input bit rand_mode);
    int n;
    int steps = 0;
    int stalls = 0;
    int cyc = 0;
    logic [W-1:0] exp;
    logic [W-1:0] prev;
    n = (m == 1 || m == 3 || m == 4 || m == 5 || m == 6) ? ((sh > W) ? W : sh) : 0;
    exp = model(m, n, model_q, d, sl, sr);
    cmd_valid = 1'b1; mode = 3'(m); shamt = CW'(sh); d_in = d;
    s_in_l = sl; s_in_r = sr; ena = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; mode = 3'(m); shamt = CW'($urandom); d_in = W'($urandom);
    while (steps < n && cyc < 200) begin
      chk("run_busy", busy, 1);
      chk("run_ready", cmd_ready, 0);
      chk("run_done", done, 0);
      prev = q;
      if ((steps == stall_at && stalls < stall_len) ||
          (rand_mode && $urandom_range(0, 3) == 0)) begin
        ena = 1'b0;
        stalls++;
      end else begin
        ena = 1'b1;
      end
      if (rand_mode) begin
        cmd_valid = 1'($urandom_range(0, 1));
        mode = 3'd2;
      end
      @(posedge clk); @(negedge clk);
      if (!ena) chk("stall_q", q, prev);
      else steps++;
      cyc++;
      ena = 1'b1;
    end
    cmd_valid = 1'b0;
    model_q = exp;
    last_lat = cyc;
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("ready_end", cmd_ready, 1);
    chk("q", q, exp);
    check_outs("cmd");
  endtask

  initial begin
    ena = 1'b1;
    #2;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 0xA5, done for exactly one cycle
    do_cmd(2, 0, 8'hA5, 0, 0, -1, 0, 0);
    chk("load_q", q, 8'hA5);
    @(negedge clk);
    chk("load_done_once", done, 0);
    chk("load_busy", busy, 0);

    do_cmd(4, 3, 8'h00, 0, 0, -1, 0, 0);
    chk("rotl_q", q, 8'h2D);
    chk("rotl_lat", last_lat, 3);

    do_cmd(3, 2, 8'h00, 0, 1, -1, 0, 0);
    chk("shr_q", q, 8'hCB);

    do_cmd(2, 0, 8'hFF, 0, 0, -1, 0, 0);
    do_cmd(1, 9, 8'h00, 0, 0, -1, 0, 0);
    chk("shl_clamp_q", q, 8'h00);
    chk("shl_clamp_lat", last_lat, 8);

    do_cmd(2, 0, 8'h80, 0, 0, -1, 0, 0);
    do_cmd(6, 4, 8'h00, 0, 0, 2, 2, 0);
    chk("ashr_q", q, 8'hF8);
    chk("ashr_lat", last_lat, 6);

    // reserved mode and zero-shift, then LOAD accepted in the done cycle
    do_cmd(2, 0, 8'h3C, 0, 0, -1, 0, 0);
    do_cmd(7, 5, 8'h11, 1, 1, -1, 0, 0);
    chk("rsvd_q", q, 8'h3C);
    do_cmd(1, 0, 8'h22, 1, 1, -1, 0, 0);
    chk("shl0_q", q, 8'h3C);
    do_cmd(2, 0, 8'h5A, 0, 0, -1, 0, 0);
    chk("b2b_q", q, 8'h5A);

    // asynchronous reset in the middle of a burst
    cmd_valid = 1'b1; mode = 3'd4; shamt = CW'(5); ena = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_q = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    for (int i = 0; i < 40; i++) begin
      do_cmd($urandom_range(0, 7), $urandom_range(0, 10), W'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_burst.md
Name: univ_shift_burst

Overview:
Parametrised next-generation universal shift register. It extends the 8-bit hold/shift/load register with configurable width, rotate and arithmetic-shift modes, and multi-position shifts. Multi-position shifts run one position per enabled cycle under a valid/ready command handshake with busy/done status. It serves as the reusable shift/serdes datapath element for the TinyTapeOut designs.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CW, $clog2(WIDTH+1), width of shift-amount field (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state (stall)
cmd_valid  in  1  command request
cmd_ready  out  1  high when block can accept a command
mode  in  3  operation select, sampled on accept
shamt  in  CW  shift/rotate count, sampled on accept
d_in  in  WIDTH  parallel load data, sampled on accept
s_in_l  in  1  serial input entering bit 0 on left shift
s_in_r  in  1  serial input entering bit WIDTH-1 on logical right shift
q  out  WIDTH  register contents
s_out_l  out  1  q[WIDTH-1]
s_out_r  out  1  q[0]
busy  out  1  high while a multi-step command executes
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, rst_n=0): q=0, state=IDLE, count=0, busy=0, done=0. Reset mid-burst aborts the command immediately; no done pulse follows.
- Mode encoding:
  - 0 HOLD
  - 1 SHL: q <= {q[W-2:0], s_in_l}
  - 2 LOAD: q <= d_in
  - 3 SHR: q <= {s_in_r, q[W-1:1]}
  - 4 ROTL
  - 5 ROTR
  - 6 ASHR: MSB replicated
  - 7 reserved, executes as HOLD
- FSM states:
  - IDLE: cmd_ready=1, busy=0.
  - RUN: cmd_ready=0, busy=1.
- Accept condition: cmd_valid & cmd_ready & ena at a rising edge. Mode, shamt and d_in are latched at that edge.
- Single-cycle commands complete on the accept edge; state stays IDLE and done=1 in the following cycle:
  - LOAD: q <= d_in at the accept edge.
  - HOLD, reserved mode, or shift/rotate with shamt=0: q unchanged.
- Shift/rotate with shamt>0:
  - Accept edge: state<=RUN, count<=min(shamt,WIDTH); q is not modified.
  - Each subsequent edge with ena=1 in RUN performs one step and decrements count.
  - The edge that takes count 1->0 performs the final step, sets state<=IDLE and done<=1 for one cycle.
  - Latency: an N-position shift shows its final q N cycles after the accept edge (with ena held high); done is visible in the same cycle.
- shamt > WIDTH clamps to WIDTH.
- Serial inputs are sampled at every step edge, not at accept.
- ena=0: no accept, no step, count frozen, q frozen. done still deasserts after its one cycle. busy stays asserted during a stall.
- cmd_valid while busy is ignored; the requester holds it until cmd_ready.
- A new command may be accepted in the same cycle done is high (back-to-back).
- s_out_l/s_out_r are combinational from q.

Optional Feature:
USHIFT_PARITY_EN
- Defined: adds output port parity (1 bit), registered. It equals the XOR of all bits of q, updated on every edge where q changes. It resets to 0.
- Not defined: the port and its logic are absent; the interface is otherwise identical.

Test Plan:
- Reset with rst_n=0 mid-run -> q=0x00, busy=0, done=0, cmd_ready=1 immediately (async); no done after release.
- LOAD d_in=0xA5 accepted -> q=0xA5 next cycle, done=1 for exactly one cycle, busy never high; parity (if enabled)=0.
- ROTL shamt=3 on q=0xA5 -> busy high 3 cycles, q=0x2D when done=1, cmd_ready=0 throughout RUN.
- SHR shamt=2, s_in_r=1, on q=0x2D -> q=0xCB at done; then SHL shamt=9 (clamped to 8), s_in_l=0, on 0xFF -> q=0x00 after 8 steps.
- ASHR shamt=4 on 0x80 with ena dropped for 2 cycles mid-burst -> done arrives 6 cycles after accept, q=0xF8; q and count frozen while ena=0.
- Mode 7 and shamt=0 SHL on 0x3C -> q stays 0x3C, done pulse next cycle; back-to-back LOAD accepted in the done cycle.
